// File: rtl/md_word_packer.sv
// Packs byte slices from the aligner MD TX stream into dense full-width words, with flush for tail words.
// Optional saturating illegal-transfer counter on err_cnt when MD_PACKER_ERR_CNT_EN is defined.
module md_word_packer #(
    parameter int ALGN_DATA_WIDTH = 32,
    localparam int N  = ALGN_DATA_WIDTH / 8,
    localparam int OW = (N > 1) ? $clog2(N) : 1,
    localparam int SW = $clog2(N) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       md_rx_valid,
    input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
    input  logic [OW-1:0]              md_rx_offset,
    input  logic [SW-1:0]              md_rx_size,
    output logic                       md_rx_ready,
    output logic                       md_rx_err,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [ALGN_DATA_WIDTH-1:0] out_data,
    output logic [SW-1:0]              out_bytes,
    input  logic                       out_ready
`ifdef MD_PACKER_ERR_CNT_EN
    ,
    output logic [7:0]                 err_cnt
`endif
);

    localparam int W = ALGN_DATA_WIDTH;
    localparam logic [SW-1:0] N_C = SW'(N);

    // Both streams: a beat transfers on a rising edge where valid && ready;
    // valid never waits on ready, and out_valid/out_data/out_bytes hold until taken.

    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [SW-1:0]  cnt;
    logic [SW-1:0]  cnt_next;
    logic [SW-1:0]  base;
    logic           flush_pend;

    logic           slot_free;
    logic           emit_full;
    logic           emit_part;
    logic           flush_clear;
    logic           accept;
    logic           legal;
    logic           take;
    logic [SW:0]    span;
    logic [W-1:0]   shifted;
    logic [W-1:0]   part_word;

    always_comb begin
        slot_free   = !out_valid || out_ready;
        emit_full   = (cnt >= N_C) && slot_free;
        md_rx_ready = !flush_pend && ((cnt < N_C) || emit_full);
        accept      = md_rx_valid && md_rx_ready;
        span        = {1'b0, md_rx_size} + (SW+1)'(md_rx_offset);
        legal       = (md_rx_size != '0) && (span <= (SW+1)'(N));
        take        = accept && legal;
        md_rx_err   = accept && !legal;
        emit_part   = flush_pend && (cnt != '0) && (cnt < N_C) && slot_free;
        flush_clear = flush_pend && ((cnt == '0) || emit_part);
    end

    // Partial tail word: oldest cnt bytes, remaining bytes forced to zero.
    always_comb begin
        part_word = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(cnt)) begin
                part_word[i*8 +: 8] = acc[i*8 +: 8];
            end
        end
    end

    // New slice lands right after the bytes that remain once a full word leaves.
    always_comb begin
        acc_next = emit_full ? (acc >> W) : acc;
        base     = emit_full ? (cnt - N_C) : cnt;
        shifted  = md_rx_data >> {md_rx_offset, 3'b000};
        if (take) begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(md_rx_size)) begin
                    acc_next[(int'(base) + i)*8 +: 8] = shifted[i*8 +: 8];
                end
            end
        end
        if (emit_part) begin
            cnt_next = '0;
        end else begin
            cnt_next = base + (take ? md_rx_size : '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (flush_clear) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (emit_full) begin
                out_valid <= 1'b1;
                out_data  <= acc[W-1:0];
                out_bytes <= N_C;
            end else if (emit_part) begin
                out_valid <= 1'b1;
                out_data  <= part_word;
                out_bytes <= cnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MD_PACKER_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (md_rx_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md_word_packer.sv
// Self-checking bench for md_word_packer: vector table, corner sequences and a byte-queue scoreboard.
// err_cnt checks are active when MD_PACKER_ERR_CNT_EN is defined.
module tb_md_word_packer;

    localparam int W  = 32;
    localparam int N  = W / 8;
    localparam int OW = 2;
    localparam int SW = 3;

    logic          clk;
    logic          reset_n;
    logic          md_rx_valid;
    logic [W-1:0]  md_rx_data;
    logic [OW-1:0] md_rx_offset;
    logic [SW-1:0] md_rx_size;
    logic          md_rx_ready;
    logic          md_rx_err;
    logic          flush;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_bytes;
    logic          out_ready;
`ifdef MD_PACKER_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    md_word_packer #(.ALGN_DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .md_rx_valid  (md_rx_valid),
        .md_rx_data   (md_rx_data),
        .md_rx_offset (md_rx_offset),
        .md_rx_size   (md_rx_size),
        .md_rx_ready  (md_rx_ready),
        .md_rx_err    (md_rx_err),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_bytes    (out_bytes),
        .out_ready    (out_ready)
`ifdef MD_PACKER_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_err_cnt = 0;
    logic rand_ready = 1'b0;

    logic [W-1:0]  exp_q[$];
    logic [SW-1:0] expb_q[$];
    logic [7:0]    bq[$];

    typedef struct {
        logic [OW-1:0] off;
        logic [SW-1:0] sz;
        logic [W-1:0]  data;
        logic          err;
    } vec_t;

    vec_t tbl[6];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    // byte-stream model: accepted bytes in order, cut into N-byte words
    task automatic model_take(input logic [OW-1:0] off, input logic [SW-1:0] sz, input logic [W-1:0] d);
        logic [W-1:0] w;
        for (int i = 0; i < int'(sz); i++) bq.push_back(d[(int'(off) + i)*8 +: 8]);
        while (bq.size() >= N) begin
            w = '0;
            for (int i = 0; i < N; i++) w[i*8 +: 8] = bq.pop_front();
            exp_q.push_back(w);
            expb_q.push_back(SW'(N));
        end
    endtask

    task automatic model_flush();
        logic [W-1:0] w;
        int n;
        n = bq.size();
        if (n > 0) begin
            w = '0;
            for (int i = 0; i < n; i++) w[i*8 +: 8] = bq.pop_front();
            exp_q.push_back(w);
            expb_q.push_back(SW'(n));
        end
    endtask

    // driver tasks
    task automatic send(input logic [OW-1:0] off, input logic [SW-1:0] sz, input logic [W-1:0] d,
                        input logic exp_err, output int waits);
        waits = 0;
        @(negedge clk);
        md_rx_valid  = 1'b1;
        md_rx_offset = off;
        md_rx_size   = sz;
        md_rx_data   = d;
        #4;
        while (!md_rx_ready && waits < 100) begin
            @(negedge clk);
            #4;
            waits++;
        end
        if (!md_rx_ready) begin
            fail_now("send_ready");
        end else begin
            chk("md_rx_err", md_rx_err, exp_err);
            if (exp_err) begin
                if (exp_err_cnt < 255) exp_err_cnt++;
            end else begin
                model_take(off, sz, d);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        md_rx_valid = 1'b0;
    endtask

    task automatic do_flush(input logic check_ready);
        @(negedge clk);
        md_rx_valid = 1'b0;
        flush = 1'b1;
        model_flush();
        @(negedge clk);
        flush = 1'b0;
        #4;
        if (check_ready) chk("ready_in_flush", md_rx_ready, 1'b0);
        @(negedge clk);
        #4;
        if (check_ready) chk("ready_after_flush", md_rx_ready, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard: compare each output handshake against the oldest expected word
    always @(negedge clk) begin
        #4;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got=%0h expected=none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
                chk("out_bytes", out_bytes, expb_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int waits;
        int acc_n;
        logic [W-1:0] held;
        logic [OW-1:0] off;
        logic [SW-1:0] sz;

        tbl[0] = '{off: 2'd0, sz: 3'd4, data: 32'h0302_0100, err: 1'b0};
        tbl[1] = '{off: 2'd0, sz: 3'd4, data: 32'h0706_0504, err: 1'b0};
        tbl[2] = '{off: 2'd1, sz: 3'd2, data: 32'hAABB_CCDD, err: 1'b0};
        tbl[3] = '{off: 2'd0, sz: 3'd3, data: 32'h1122_3344, err: 1'b0};
        tbl[4] = '{off: 2'd3, sz: 3'd2, data: 32'h5555_5555, err: 1'b1};
        tbl[5] = '{off: 2'd0, sz: 3'd0, data: 32'h6666_6666, err: 1'b1};

        reset_n = 1'b0;
        md_rx_valid = 1'b0;
        md_rx_data = '0;
        md_rx_offset = '0;
        md_rx_size = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_ready", md_rx_ready, 1'b1);
        chk("rst_err", md_rx_err, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_bytes", out_bytes, 3'd0);
`ifdef MD_PACKER_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 8'd0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // vector table: back-to-back words, slice packing, tail flush, illegal transfers
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].off, tbl[i].sz, tbl[i].data, tbl[i].err, waits);
            if (i < 2) chk("b2b_no_stall", 64'(waits), 64'd0);
            if (i == 3) do_flush(1'b1);
        end
        idle();
        @(negedge clk);
        #4;
`ifdef MD_PACKER_ERR_CNT_EN
        chk("err_cnt", err_cnt, 8'(exp_err_cnt));
`endif
        chk("no_out_after_err", out_valid, 1'b0);
        drain();

        // backpressure: only two size-4 transfers fit while the sink stalls
        out_ready = 1'b0;
        acc_n = 0;
        held = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            md_rx_valid  = 1'b1;
            md_rx_offset = '0;
            md_rx_size   = 3'd4;
            md_rx_data   = 32'hB0B0_0000 + W'(acc_n);
            #4;
            if (md_rx_ready) begin
                model_take(2'd0, 3'd4, md_rx_data);
                acc_n++;
            end
            if (c == 3) held = out_data;
        end
        chk("bp_accepted", 64'(acc_n), 64'd2);
        chk("bp_ready_low", md_rx_ready, 1'b0);
        chk("bp_valid_held", out_valid, 1'b1);
        chk("bp_data_stable", out_data, held);
        idle();
        out_ready = 1'b1;
        drain();

        // asynchronous reset with a partial word buffered and a word held at the output
        out_ready = 1'b0;
        send(2'd0, 3'd4, 32'hDEAD_0001, 1'b0, waits);
        send(2'd0, 3'd3, 32'h00C0_FFEE, 1'b0, waits);
        idle();
        #4;
        chk("pre_rst_valid", out_valid, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_data", out_data, 32'h0);
        chk("async_rst_ready", md_rx_ready, 1'b1);
`ifdef MD_PACKER_ERR_CNT_EN
        chk("async_rst_err_cnt", err_cnt, 8'd0);
`endif
        bq.delete();
        exp_q.delete();
        expb_q.delete();
        exp_err_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(2'd0, 3'd4, 32'h4433_2211, 1'b0, waits);
        idle();
        drain();

        // random legal slices under random sink stalls with periodic flushes
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            off = OW'($urandom_range(0, N - 1));
            sz  = SW'($urandom_range(1, N - int'(off)));
            send(off, sz, $urandom, 1'b0, waits);
            if (i % 10 == 9) do_flush(1'b0);
        end
        do_flush(1'b0);
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
